// File: rtl/data_memory.sv
// Word-organised MIPS data memory mapped at BASE_ADDR, addressed by the ALU byte address.
// Latency: reads are combinational; writes and reset land on the rising clk edge.
// Backpressure: none; every access completes in a single cycle.
module data_memory #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          DEPTH     = 256,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    output logic [31:0] data_result
);

    // Power-up value keeps contents defined before the first reset.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          in_range;
    logic          unused_offset_bits;

    // Byte-lane bits are dropped: a misaligned address hits its containing word.
    assign offset             = ALUresult - BASE_ADDR;
    assign index              = offset[AW+1:2];
    assign in_range           = (ALUresult >= BASE_ADDR) && (offset[31:AW+2] == '0);
    assign unused_offset_bits = ^offset[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite && in_range) begin
            mem[index] <= WriteData;
        end
    end

    // No write-through: a same-cycle write becomes visible only after the edge.
    always_comb begin
        data_result = '0;
        if (MemRead && in_range) begin
            data_result = mem[index];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed MIPS test plan with literal expectations, then
// randomized traffic compared every cycle against a word-array reference model.
module tb_data_memory;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ALUresult;
    logic [31:0] WriteData;
    logic [31:0] data_result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];

    data_memory #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .ALUresult   (ALUresult),
        .WriteData   (WriteData),
        .data_result (data_result)
    );

    always #5 clk = ~clk;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] model_read(input logic mr, input logic [31:0] a);
        if (!mr || !addr_ok(a)) return 32'h0;
        return model_mem[(a - BASE) / 4];
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    end

    // Reference state advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        end else if (MemWrite && addr_ok(ALUresult)) begin
            model_mem[(ALUresult - BASE) / 4] = WriteData;
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_v;
        exp_v = model_read(MemRead, ALUresult);
        n_checks++;
        if (data_result !== exp_v) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t addr=%h rd=%0b wr=%0b got=%h exp=%h",
                     $time, ALUresult, MemRead, MemWrite, data_result, exp_v);
        end
    end

    // Apply one cycle of inputs, optionally check a literal before the edge, then take the edge.
    task automatic access(input logic rst, input logic mw, input logic mr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit chk, input logic [31:0] exp_v, input string name);
        reset     = rst;
        MemWrite  = mw;
        MemRead   = mr;
        ALUresult = addr;
        WriteData = wd;
        @(negedge clk);
        if (chk) begin
            n_checks++;
            if (data_result !== exp_v) begin
                n_fail++;
                $display("FAIL %s got=%h exp=%h", name, data_result, exp_v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_v, input string name);
        access(1'b0, 1'b0, 1'b1, addr, 32'h0, 1'b1, exp_v, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        access(1'b0, 1'b1, 1'b0, addr, wd, 1'b0, 32'h0, "wr");
    endtask

    int fib [12];

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
        ALUresult = 32'h0; WriteData = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        rd(32'h1001_0000, 32'h0, "rst_rd_w0");
        rd(32'h1001_0004, 32'h0, "rst_rd_w1");
        rd(32'h1001_03FC, 32'h0, "rst_rd_last");

        fib[0] = 1; fib[1] = 1;
        for (int n = 2; n < 12; n++) fib[n] = fib[n-1] + fib[n-2];

        wr(32'h1001_0000, 32'd1);
        wr(32'h1001_0004, 32'd1);
        rd(32'h1001_0000, 32'd1, "f0");
        rd(32'h1001_0004, 32'd1, "f1");

        for (int n = 2; n < 12; n++) begin
            wr(BASE + 32'(4 * n), 32'(fib[n]));
            rd(BASE + 32'(4 * (n - 1)), 32'(fib[n-1]), "fib_prev");
            rd(BASE + 32'(4 * n), 32'(fib[n]), "fib_cur");
        end
        rd(32'h1001_0024, 32'd55, "fib9_lit");
        rd(32'h1001_002C, 32'd144, "fib11_lit");
        rd(32'h1001_0006, 32'd1, "misaligned");

        access(1'b0, 1'b0, 1'b0, 32'h1001_0024, 32'h0, 1'b1, 32'h0, "rd_disabled");
        access(1'b0, 1'b1, 1'b0, 32'h1001_0024, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr_no_rd");
        rd(32'h1001_0024, 32'hFFFF_FFFF, "wr_no_rd_took");
        wr(32'h1001_0024, 32'd55);

        access(1'b0, 1'b1, 1'b1, 32'h1001_0030, 32'hDEAD_BEEF, 1'b1, 32'h0, "rw_before");
        access(1'b0, 1'b1, 1'b1, 32'h1001_0030, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "rw_after");

        wr(32'h1000_FFFC, 32'd7);
        wr(32'h1001_0400, 32'd9);
        rd(32'h1000_FFFC, 32'h0, "below_rd");
        rd(32'h1001_0400, 32'h0, "above_rd");
        rd(32'h1001_03FC, 32'h0, "last_untouched");
        rd(32'h1001_0000, 32'd1, "w0_unchanged");

        access(1'b1, 1'b1, 1'b0, 32'h1001_0000, 32'h1234_5678, 1'b0, 32'h0, "rst_wr");
        for (int n = 0; n < 12; n++) rd(BASE + 32'(4 * n), 32'h0, "post_rst");

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                3:       a = BASE - 32'($urandom_range(1, 64));
                4:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
                default: a = $urandom;
            endcase
            access(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 3) != 0), a, $urandom, 1'b0, 32'h0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
